// File: rtl/icache_pkg.sv
// Shared types and defaults for the i-cache refill path.
// Address layout: [tag | index | word offset | byte offset].
package icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2,
        ST_ERR  = 2'd3
    } refill_state_e;

    localparam int DEF_BLOCK_SIZE = 2;
    localparam int DEF_LINE_SIZE  = 32;
    localparam int DEF_INDEX_SIZE = 3;
    localparam int DEF_ADDR_SIZE  = 32;
    localparam int DEF_TIMEOUT    = 64;

    localparam int BYTE_OFF_W     = 2;

    function automatic int tag_width(input int addr_w, input int index_w, input int block_w);
        return addr_w - index_w - block_w - BYTE_OFF_W;
    endfunction

endpackage

// File: rtl/icache_refill_timer.sv
// Loadable saturating down-counter; expired is high once the count reaches zero.
// Loading TIMEOUT-1 gives exactly TIMEOUT enabled cycles before expiry.
module icache_refill_timer
    import icache_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic c_clk_i,
    input  logic c_reset_n_i,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge c_clk_i or negedge c_reset_n_i) begin
        if (!c_reset_n_i) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= CNT_W'(TIMEOUT - 1);
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache refill initiator: latches the miss, holds the block read until done,
// then writes the line in one pulse or flags a timeout.
//
// state | meaning
// IDLE  | waiting for a miss
// REQ   | block read held to memory, timeout running
// FILL  | one-cycle line write with captured block
// ERR   | one-cycle timeout pulse, no line write
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int c_block_size = DEF_BLOCK_SIZE,
    parameter int c_line_size  = DEF_LINE_SIZE,
    parameter int c_index_size = DEF_INDEX_SIZE,
    parameter int address_size = DEF_ADDR_SIZE,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic                                                     c_clk_i,
    input  logic                                                     c_reset_n_i,
    input  logic                                                     c_miss_i,
    input  logic [address_size-1:0]                                  c_miss_addr_i,
    output logic                                                     c_busy_o,
    output logic                                                     c_refill_we_o,
    output logic [c_index_size-1:0]                                  c_refill_index_o,
    output logic [address_size-c_index_size-c_block_size-2-1:0]      c_refill_tag_o,
    output logic [(2**c_block_size)*c_line_size-1:0]                 c_refill_data_o,
    output logic [c_line_size-1:0]                                   c_crit_word_o,
    output logic                                                     c_err_o,
    output logic                                                     m_read_o,
    output logic [address_size-c_block_size-2-1:0]                   m_addr_o,
    input  logic                                                     m_busywait_i,
    input  logic                                                     m_read_done_i,
    input  logic [(2**c_block_size)*c_line_size-1:0]                 m_read_data_i
);

    localparam int WORDS   = 2**c_block_size;
    localparam int BLOCK_W = WORDS * c_line_size;
    localparam int TAG_W   = tag_width(address_size, c_index_size, c_block_size);
    localparam int WADDR_W = address_size - BYTE_OFF_W;

    refill_state_e state_q, state_d;

    // Byte offset is never needed, so only the word address is kept.
    logic [WADDR_W-1:0]     addr_q;
    logic [BLOCK_W-1:0]     block_q;
    logic [c_line_size-1:0] crit_q;
    logic [c_line_size-1:0] crit_d;
    logic                   start_miss;
    logic                   capture;
    logic                   tmr_expired;

    logic unused_ok;
    assign unused_ok = ^{c_miss_addr_i[BYTE_OFF_W-1:0], m_busywait_i};

    assign start_miss = (state_q == ST_IDLE) && c_miss_i;
    assign capture    = (state_q == ST_REQ) && m_read_done_i;

    icache_refill_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .c_clk_i     (c_clk_i),
        .c_reset_n_i (c_reset_n_i),
        .load        (start_miss),
        .en          (state_q == ST_REQ),
        .expired     (tmr_expired)
    );

    always_ff @(posedge c_clk_i or negedge c_reset_n_i) begin
        if (!c_reset_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Done has priority over the timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (c_miss_i) state_d = ST_REQ;
            ST_REQ: begin
                if (m_read_done_i) begin
                    state_d = ST_FILL;
                end else if (tmr_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_FILL: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_read_o      = 1'b0;
        c_busy_o      = 1'b0;
        c_refill_we_o = 1'b0;
        c_err_o       = 1'b0;
        case (state_q)
            ST_REQ: begin
                m_read_o = 1'b1;
                c_busy_o = 1'b1;
            end
            ST_FILL: begin
                c_refill_we_o = 1'b1;
                c_busy_o      = 1'b1;
            end
            ST_ERR:  c_err_o = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        crit_d = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (i == int'(addr_q[c_block_size-1:0])) begin
                crit_d = m_read_data_i[i*c_line_size +: c_line_size];
            end
        end
    end

    always_ff @(posedge c_clk_i or negedge c_reset_n_i) begin
        if (!c_reset_n_i) begin
            addr_q  <= '0;
            block_q <= '0;
            crit_q  <= '0;
        end else begin
            if (start_miss) begin
                addr_q <= c_miss_addr_i[address_size-1:BYTE_OFF_W];
            end
            if (capture) begin
                block_q <= m_read_data_i;
                crit_q  <= crit_d;
            end
        end
    end

    assign c_refill_index_o = addr_q[c_block_size +: c_index_size];
    assign c_refill_tag_o   = addr_q[WADDR_W-1 -: TAG_W];
    assign m_addr_o         = addr_q[WADDR_W-1:c_block_size];
    assign c_refill_data_o  = block_q;
    assign c_crit_word_o    = crit_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: directed cases plus randomized
// refills compared against a transaction-level model of the refill rules.
module tb_icache_refill_ctrl;

    localparam int TIMEOUT = 64;

    logic         clk;
    logic         rst_n;
    logic         miss;
    logic [31:0]  miss_addr;
    logic         busy;
    logic         we;
    logic [2:0]   idx;
    logic [24:0]  tag;
    logic [127:0] rdata_out;
    logic [31:0]  crit;
    logic         err;
    logic         m_read;
    logic [27:0]  m_addr;
    logic         busywait;
    logic         done;
    logic [127:0] mdata;

    int n_cmp = 0;
    int n_err = 0;
    int n_bursts = 0, exp_bursts = 0;
    int n_we = 0, exp_we = 0;
    int n_errp = 0, exp_errp = 0;
    logic read_prev = 1'b0;

    icache_refill_ctrl #(
        .c_block_size (2),
        .c_line_size  (32),
        .c_index_size (3),
        .address_size (32),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .c_clk_i          (clk),
        .c_reset_n_i      (rst_n),
        .c_miss_i         (miss),
        .c_miss_addr_i    (miss_addr),
        .c_busy_o         (busy),
        .c_refill_we_o    (we),
        .c_refill_index_o (idx),
        .c_refill_tag_o   (tag),
        .c_refill_data_o  (rdata_out),
        .c_crit_word_o    (crit),
        .c_err_o          (err),
        .m_read_o         (m_read),
        .m_addr_o         (m_addr),
        .m_busywait_i     (busywait),
        .m_read_done_i    (done),
        .m_read_data_i    (mdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory-side observer: bursts are rising edges of the read request.
    always @(negedge clk) begin
        if (m_read && !read_prev) n_bursts++;
        read_prev = m_read;
        if (we)  n_we++;
        if (err) n_errp++;
    end

    task automatic check_val(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check_val({name, "_we"},   128'(we),     128'(0));
        check_val({name, "_err"},  128'(err),    128'(0));
        check_val({name, "_busy"}, 128'(busy),   128'(0));
        check_val({name, "_read"}, 128'(m_read), 128'(0));
    endtask

    // One refill transaction: done arrives in REQ cycle 'lat' (0 = same cycle
    // the request first appears); lat >= TIMEOUT means memory never answers.
    task automatic do_refill(input logic [31:0] addr, input int lat,
                             input logic [127:0] blk, input bit hold);
        logic [31:0] e_maddr, e_idx, e_tag, e_crit;
        int          w;
        bit          ok;
        e_maddr = addr >> 4;
        e_idx   = (addr >> 4) % 8;
        e_tag   = addr >> 7;
        w       = int'((addr >> 2) % 4);
        e_crit  = blk[w*32 +: 32];
        ok      = (lat < TIMEOUT);
        exp_bursts++;
        if (ok) exp_we++; else exp_errp++;

        @(negedge clk);
        miss = 1'b1; miss_addr = addr; done = 1'b0;
        mdata = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        check_val("req_read", 128'(m_read), 128'(1));
        check_val("req_busy", 128'(busy), 128'(1));
        check_val("m_addr", 128'(m_addr), 128'(e_maddr));
        for (int cyc = 0; cyc <= TIMEOUT; cyc++) begin
            @(negedge clk);
            miss      = hold && (cyc < lat) && (cyc < TIMEOUT - 1);
            miss_addr = hold ? addr : $urandom;
            done      = (cyc == lat);
            busywait  = !done;
            mdata     = done ? blk : {$urandom, $urandom, $urandom, $urandom};
            check_val("read_held", 128'(m_read), 128'(1));
            @(posedge clk); #1;
            if (cyc == lat) begin
                check_val("fill_we",    128'(we),     128'(1));
                check_val("fill_busy",  128'(busy),   128'(1));
                check_val("fill_read",  128'(m_read), 128'(0));
                check_val("fill_err",   128'(err),    128'(0));
                check_val("fill_index", 128'(idx),    128'(e_idx));
                check_val("fill_tag",   128'(tag),    128'(e_tag));
                check_val("fill_data",  rdata_out,    blk);
                check_val("fill_crit",  128'(crit),   128'(e_crit));
                check_val("fill_maddr", 128'(m_addr), 128'(e_maddr));
                break;
            end
            if (cyc == TIMEOUT - 1) begin
                check_val("err_pulse", 128'(err),    128'(1));
                check_val("err_we",    128'(we),     128'(0));
                check_val("err_busy",  128'(busy),   128'(0));
                check_val("err_read",  128'(m_read), 128'(0));
                break;
            end
        end
        @(negedge clk);
        done = 1'b0; busywait = 1'b0; miss = 1'b0;
        @(posedge clk); #1;
        check_idle("post");
    endtask

    initial begin
        logic [31:0]  a;
        logic [127:0] b;
        int           sel, lat;
        rst_n = 1'b0; miss = 1'b0; miss_addr = '0; done = 1'b0;
        busywait = 1'b0; mdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        check_val("reset_data",  rdata_out,    128'(0));
        check_val("reset_maddr", 128'(m_addr), 128'(0));
        check_val("reset_crit",  128'(crit),   128'(0));
        @(negedge clk); rst_n = 1'b1;

        // Basic refill
        do_refill(32'h0000_0124, 6, {32'h4, 32'h3, 32'h2, 32'h1}, 1'b0);
        // Back-to-back misses
        do_refill(32'h0000_0000, 3, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b1);
        do_refill(32'h0000_0010, 4, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 1'b0);
        // Timeout, then done coincident with the last timeout cycle
        do_refill(32'h1234_5678, TIMEOUT + 10, 128'h0, 1'b0);
        do_refill(32'hDEAD_BEEC, TIMEOUT - 1, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 1'b1);
        do_refill(32'h0000_0FF8, 0, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 1'b0);

        // Asynchronous reset mid-REQ
        @(negedge clk);
        miss = 1'b1; miss_addr = 32'h0000_05A4;
        exp_bursts++;
        @(posedge clk); #1;
        miss = 1'b0;
        repeat (3) @(posedge clk);
        #2; rst_n = 1'b0; #1;
        check_idle("async_rst");
        check_val("async_rst_data",  rdata_out,    128'(0));
        check_val("async_rst_index", 128'(idx),    128'(0));
        check_val("async_rst_tag",   128'(tag),    128'(0));
        check_val("async_rst_crit",  128'(crit),   128'(0));
        check_val("async_rst_maddr", 128'(m_addr), 128'(0));
        miss = 1'b1; miss_addr = 32'h0000_0A5C;
        @(posedge clk); #2; rst_n = 1'b1;
        do_refill(32'h0000_0A5C, 5, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 1'b0);

        // Randomized refills
        for (int t = 0; t < 16; t++) begin
            a   = $urandom;
            b   = {$urandom, $urandom, $urandom, $urandom};
            sel = $urandom_range(0, 9);
            if (sel == 0)      lat = TIMEOUT - 1;
            else if (sel == 1) lat = TIMEOUT + $urandom_range(0, 5);
            else               lat = $urandom_range(0, 12);
            do_refill(a, lat, b, 1'($urandom_range(0, 1)));
        end

        repeat (2) @(posedge clk);
        #1;
        check_val("burst_count", 128'(n_bursts), 128'(exp_bursts));
        check_val("we_count",    128'(n_we),     128'(exp_we));
        check_val("err_count",   128'(n_errp),   128'(exp_errp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
